// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BUSY_IF,
        BUSY_D,
        RESP_IF,
        RESP_D
    } arb_state_t;

    localparam int ARB_AW = 32;
    localparam int ARB_DW = 32;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_D  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Fetch-starvation counter: counts data grants made while fetch waits.
// Only instantiated when ARB_STARVE_GUARD_EN is defined.
module arb_starve_ctr #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic grant_d_i,
    input  logic grant_if_i,
    input  logic if_req_i,
    output logic fetch_prio_o
);

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (grant_if_i) begin
            cnt_d = '0;
        end else if (grant_d_i && if_req_i && (cnt_q != CW'(STARVE_MAX))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fetch_prio_o = (cnt_q == CW'(STARVE_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Data has priority; define ARB_STARVE_GUARD_EN to bound fetch starvation.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW         = ARB_AW,
    parameter int DW         = ARB_DW,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          mem_valid,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          stall_fetch,
    output logic          stall_all
);

    arb_state_t    state_q, state_d;
    logic          memValid_q, memValid_d;
    logic          memWe_q, memWe_d;
    logic [AW-1:0] memAddr_q, memAddr_d;
    logic [DW-1:0] memWdata_q, memWdata_d;
    logic [DW-1:0] ifRdata_q, ifRdata_d;
    logic [DW-1:0] dRdata_q, dRdata_d;
    logic          grantSel;
    logic          fetchPrio;

    always_comb begin
        state_d    = state_q;
        memValid_d = memValid_q;
        memWe_d    = memWe_q;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        ifRdata_d  = ifRdata_q;
        dRdata_d   = dRdata_q;
        grantSel   = (d_req && !(if_req && fetchPrio)) ? REQ_D : REQ_IF;

        case (state_q)
            IDLE: begin
                if (d_req || if_req) begin
                    memValid_d = 1'b1;
                    if (grantSel == REQ_D) begin
                        state_d    = BUSY_D;
                        memWe_d    = d_we;
                        memAddr_d  = d_addr;
                        memWdata_d = d_wdata;
                    end else begin
                        state_d    = BUSY_IF;
                        memWe_d    = 1'b0;
                        memAddr_d  = if_addr;
                        memWdata_d = '0;
                    end
                end
            end
            BUSY_IF: begin
                if (mem_ack) begin
                    ifRdata_d  = mem_rdata;
                    memValid_d = 1'b0;
                    state_d    = RESP_IF;
                end
            end
            BUSY_D: begin
                // A store completes without disturbing the last load result.
                if (mem_ack) begin
                    if (!memWe_q) begin
                        dRdata_d = mem_rdata;
                    end
                    memValid_d = 1'b0;
                    state_d    = RESP_D;
                end
            end
            RESP_IF, RESP_D: begin
                state_d = IDLE;
            end
            default: begin
                state_d    = IDLE;
                memValid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            memValid_q <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            ifRdata_q  <= '0;
            dRdata_q   <= '0;
        end else begin
            state_q    <= state_d;
            memValid_q <= memValid_d;
            memWe_q    <= memWe_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            ifRdata_q  <= ifRdata_d;
            dRdata_q   <= dRdata_d;
        end
    end

`ifdef ARB_STARVE_GUARD_EN
    logic grantD;
    logic grantIf;

    assign grantD  = (state_q == IDLE) && (state_d == BUSY_D);
    assign grantIf = (state_q == IDLE) && (state_d == BUSY_IF);

    arb_starve_ctr #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve_ctr (
        .clk         (clk),
        .rst         (rst),
        .grant_d_i   (grantD),
        .grant_if_i  (grantIf),
        .if_req_i    (if_req),
        .fetch_prio_o(fetchPrio)
    );
`else
    assign fetchPrio = 1'b0;
`endif

    assign mem_valid   = memValid_q;
    assign mem_we      = memWe_q;
    assign mem_addr    = memAddr_q;
    assign mem_wdata   = memWdata_q;
    assign if_rdata    = ifRdata_q;
    assign d_rdata     = dRdata_q;
    assign if_done     = (state_q == RESP_IF);
    assign d_done      = (state_q == RESP_D);
    assign stall_fetch = if_req & (state_q != RESP_IF);
    assign stall_all   = d_req & (state_q != RESP_D);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; honours ARB_STARVE_GUARD_EN.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifReq;
    logic [31:0] ifAddr;
    logic [31:0] ifRdata;
    logic        ifDone;
    logic        dReq;
    logic        dWe;
    logic [31:0] dAddr;
    logic [31:0] dWdata;
    logic [31:0] dRdata;
    logic        dDone;
    logic        memValid;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [31:0] memRdata;
    logic        memAck;
    logic        stallFetch;
    logic        stallAll;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (ifReq),
        .if_addr    (ifAddr),
        .if_rdata   (ifRdata),
        .if_done    (ifDone),
        .d_req      (dReq),
        .d_we       (dWe),
        .d_addr     (dAddr),
        .d_wdata    (dWdata),
        .d_rdata    (dRdata),
        .d_done     (dDone),
        .mem_valid  (memValid),
        .mem_we     (memWe),
        .mem_addr   (memAddr),
        .mem_wdata  (memWdata),
        .mem_rdata  (memRdata),
        .mem_ack    (memAck),
        .stall_fetch(stallFetch),
        .stall_all  (stallAll)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic iReq, input logic [31:0] iAddr, input logic dr,
                                 input logic we, input logic [31:0] da, input logic [31:0] dw);
        ifReq  = iReq;
        ifAddr = iAddr;
        dReq   = dr;
        dWe    = we;
        dAddr  = da;
        dWdata = dw;
    endtask

    task automatic driveMem(input logic ack, input logic [31:0] rdata);
        memAck   = ack;
        memRdata = rdata;
    endtask

    // Each cycle: wait past the edge, drive inputs, settle, then check.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    int grantKind[10];
    int nGrant;
    int expKind;

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        driveMem(1'b0, 32'h0);
        nextCycle();
        nextCycle();
        #1;
        checkOutput("rst_mem_valid", {31'b0, memValid}, 32'h0);
        checkOutput("rst_mem_we", {31'b0, memWe}, 32'h0);
        checkOutput("rst_mem_addr", memAddr, 32'h0);
        checkOutput("rst_mem_wdata", memWdata, 32'h0);
        checkOutput("rst_if_rdata", ifRdata, 32'h0);
        checkOutput("rst_d_rdata", dRdata, 32'h0);
        checkOutput("rst_dones", {30'b0, ifDone, dDone}, 32'h0);
        checkOutput("rst_stalls", {30'b0, stallFetch, stallAll}, 32'h0);

        // Lone fetch, zero-wait memory.
        nextCycle();
        rst = 1'b0;
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checkOutput("if_t_stall_fetch", {31'b0, stallFetch}, 32'h1);
        checkOutput("if_t_mem_valid", {31'b0, memValid}, 32'h0);
        nextCycle();
        driveMem(1'b1, 32'h00500093);
        #1;
        checkOutput("if_t1_mem_valid", {31'b0, memValid}, 32'h1);
        checkOutput("if_t1_mem_addr", memAddr, 32'h40);
        checkOutput("if_t1_mem_we", {31'b0, memWe}, 32'h0);
        checkOutput("if_t1_done", {31'b0, ifDone}, 32'h0);
        nextCycle();
        driveMem(1'b0, 32'h0);
        #1;
        checkOutput("if_t2_done", {31'b0, ifDone}, 32'h1);
        checkOutput("if_t2_rdata", ifRdata, 32'h00500093);
        checkOutput("if_t2_stall_fetch", {31'b0, stallFetch}, 32'h0);
        checkOutput("if_t2_mem_valid", {31'b0, memValid}, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checkOutput("if_t3_done", {31'b0, ifDone}, 32'h0);

        // Simultaneous requests: data first, fetch after.
        nextCycle();
        applyStimulus(1'b1, 32'h44, 1'b1, 1'b0, 32'h100, 32'h0);
        #1;
        checkOutput("both_t_stall_all", {31'b0, stallAll}, 32'h1);
        nextCycle();
        driveMem(1'b1, 32'h11112222);
        #1;
        checkOutput("both_t1_mem_addr", memAddr, 32'h100);
        checkOutput("both_t1_stall_all", {31'b0, stallAll}, 32'h1);
        nextCycle();
        driveMem(1'b0, 32'h0);
        #1;
        checkOutput("both_t2_d_done", {31'b0, dDone}, 32'h1);
        checkOutput("both_t2_d_rdata", dRdata, 32'h11112222);
        checkOutput("both_t2_stall_all", {31'b0, stallAll}, 32'h0);
        checkOutput("both_t2_if_done", {31'b0, ifDone}, 32'h0);
        nextCycle();
        applyStimulus(1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checkOutput("both_t3_mem_valid", {31'b0, memValid}, 32'h0);
        nextCycle();
        driveMem(1'b1, 32'h33334444);
        #1;
        checkOutput("both_t4_mem_addr", memAddr, 32'h44);
        checkOutput("both_t4_mem_valid", {31'b0, memValid}, 32'h1);
        nextCycle();
        driveMem(1'b0, 32'h0);
        #1;
        checkOutput("both_t5_if_done", {31'b0, ifDone}, 32'h1);
        checkOutput("both_t5_if_rdata", ifRdata, 32'h33334444);
        checkOutput("both_t5_d_rdata", dRdata, 32'h11112222);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Store with three wait cycles.
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h104, 32'hDEADBEEF);
        for (int c = 1; c <= 4; c++) begin
            nextCycle();
            driveMem((c == 4) ? 1'b1 : 1'b0, 32'hFFFF0000);
            #1;
            checkOutput($sformatf("st_t%0d_mem_valid", c), {31'b0, memValid}, 32'h1);
            checkOutput($sformatf("st_t%0d_mem_we", c), {31'b0, memWe}, 32'h1);
            checkOutput($sformatf("st_t%0d_mem_addr", c), memAddr, 32'h104);
            checkOutput($sformatf("st_t%0d_mem_wdata", c), memWdata, 32'hDEADBEEF);
            checkOutput($sformatf("st_t%0d_d_done", c), {31'b0, dDone}, 32'h0);
        end
        nextCycle();
        driveMem(1'b0, 32'h0);
        #1;
        checkOutput("st_t5_d_done", {31'b0, dDone}, 32'h1);
        checkOutput("st_t5_d_rdata", dRdata, 32'h11112222);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Stray ack while idle.
        nextCycle();
        driveMem(1'b1, 32'hCAFEF00D);
        nextCycle();
        driveMem(1'b0, 32'h0);
        #1;
        checkOutput("stray_dones", {30'b0, ifDone, dDone}, 32'h0);
        checkOutput("stray_mem_valid", {31'b0, memValid}, 32'h0);
        checkOutput("stray_if_rdata", ifRdata, 32'h33334444);
        nextCycle();
        #1;
        checkOutput("stray_dones2", {30'b0, ifDone, dDone}, 32'h0);

        // Reset during an outstanding data access.
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0);
        nextCycle();
        #1;
        checkOutput("mrst_mem_valid_before", {31'b0, memValid}, 32'h1);
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checkOutput("mrst_mem_valid", {31'b0, memValid}, 32'h0);
        checkOutput("mrst_d_done", {31'b0, dDone}, 32'h0);
        checkOutput("mrst_if_rdata", ifRdata, 32'h0);
        checkOutput("mrst_d_rdata", dRdata, 32'h0);
        nextCycle();
        #1;
        checkOutput("mrst_idle_mem_valid", {31'b0, memValid}, 32'h0);
        checkOutput("mrst_idle_dones", {30'b0, ifDone, dDone}, 32'h0);

        // Both requests held continuously; record who gets each grant.
        for (int i = 0; i < 10; i++) grantKind[i] = 2;
        nGrant = 0;
        nextCycle();
        applyStimulus(1'b1, 32'h80, 1'b1, 1'b0, 32'h300, 32'h0);
        for (int c = 0; c < 45; c++) begin
            nextCycle();
            #1;
            if (memValid) begin
                if (nGrant < 10) begin
                    grantKind[nGrant] = (memAddr == 32'h80) ? 1 : 0;
                    nGrant++;
                end
                driveMem(1'b1, 32'h0);
            end else begin
                driveMem(1'b0, 32'h0);
            end
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int c = 0; c < 6; c++) begin
            nextCycle();
            #1;
            driveMem(memValid, 32'h0);
        end
        for (int i = 0; i < 10; i++) begin
`ifdef ARB_STARVE_GUARD_EN
            expKind = ((i % 5) == 4) ? 1 : 0;
`else
            expKind = 0;
`endif
            checkOutput($sformatf("starve_grant%0d", i), grantKind[i], expKind);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
